// File: rtl/inst_fetch.sv
// Instruction fetch unit: one outstanding memory read, 2-entry {pc, inst} buffer
// feeding the instruction register, with branch redirect and in-flight response flush.
module inst_fetch #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] NOP_INST = 16'h4300
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_rvalid,
    input  logic [15:0] mem_rdata,
    input  logic        ir_ready,
    output logic        ir_wen,
    output logic [15:0] inst_out,
    output logic [15:0] pc_out,
    input  logic        br_taken,
    input  logic [15:0] br_target
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_FLUSH} state_e;

    state_e      state_q, state_d;
    logic [15:0] fetch_pc_q, fetch_pc_d;
    logic [15:0] req_pc_q, req_pc_d;
    logic [15:0] fifo_pc_q   [2];
    logic [15:0] fifo_inst_q [2];
    logic        rd_ptr_q, wr_ptr_q;
    logic [1:0]  cnt_q;

    logic empty, issue, push, pop;

    assign empty = (cnt_q == 2'd0);
    assign issue = (state_q == S_IDLE) && !br_taken && (cnt_q != 2'd2);
    assign push  = (state_q == S_WAIT) && mem_rvalid && !br_taken;
    assign pop   = ir_wen;

    // Outputs are forced to their idle values while reset is held, independent of state.
    assign mem_req  = issue && !reset;
    assign mem_addr = fetch_pc_q;
    assign ir_wen   = !empty && ir_ready && !br_taken && !reset;
    assign inst_out = (reset || empty) ? NOP_INST : fifo_inst_q[rd_ptr_q];
    assign pc_out   = reset ? RESET_PC : (empty ? fetch_pc_q : fifo_pc_q[rd_ptr_q]);

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        if (br_taken) begin
            fetch_pc_d = br_target;
            // A response still in flight must be swallowed before fetching resumes.
            if (state_q != S_IDLE)
                state_d = mem_rvalid ? S_IDLE : S_FLUSH;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (issue) begin
                        req_pc_d   = fetch_pc_q;
                        fetch_pc_d = fetch_pc_q + 16'd1;
                        state_d    = S_WAIT;
                    end
                end
                S_WAIT:  if (mem_rvalid) state_d = S_IDLE;
                S_FLUSH: if (mem_rvalid) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= RESET_PC;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            cnt_q      <= 2'd0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            if (br_taken) begin
                rd_ptr_q <= 1'b0;
                wr_ptr_q <= 1'b0;
                cnt_q    <= 2'd0;
            end else begin
                if (push) begin
                    fifo_pc_q[wr_ptr_q]   <= req_pc_q;
                    fifo_inst_q[wr_ptr_q] <= mem_rdata;
                    wr_ptr_q              <= ~wr_ptr_q;
                end
                if (pop)
                    rd_ptr_q <= ~rd_ptr_q;
                cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Randomized bench for inst_fetch: variable-latency memory model plus a
// queue-based reference of the fetch/redirect rules, checked every cycle.
module tb_inst_fetch;

    localparam logic [15:0] RESET_PC = 16'h0000;
    localparam logic [15:0] NOP_INST = 16'h4300;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_rvalid;
    logic [15:0] mem_rdata;
    logic        ir_ready;
    logic        ir_wen;
    logic [15:0] inst_out;
    logic [15:0] pc_out;
    logic        br_taken;
    logic [15:0] br_target;

    inst_fetch #(.RESET_PC(RESET_PC), .NOP_INST(NOP_INST)) dut (
        .clk(clk), .reset(reset),
        .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .ir_ready(ir_ready), .ir_wen(ir_wen),
        .inst_out(inst_out), .pc_out(pc_out),
        .br_taken(br_taken), .br_target(br_target)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    // Memory: responses serialized, at least one cycle after their request.
    typedef struct { int due; logic [15:0] data; } resp_t;
    resp_t mem_q[$];
    int    last_due = -1;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return (a * 16'h9E37) ^ 16'h5A5A;
    endfunction

    // Reference: fetched-but-undelivered words, the pc of the next fetch,
    // whether a read is in flight and whether its data is to be thrown away.
    typedef struct { logic [15:0] pc; logic [15:0] inst; } ent_t;
    ent_t        m_buf[$];
    logic [15:0] m_pc     = RESET_PC;
    logic [15:0] m_req_pc = RESET_PC;
    bit          m_out    = 0;
    bit          m_drop   = 0;

    task automatic step(input bit rst, input bit br, input logic [15:0] tgt,
                        input bit rdy, input int lat);
        bit          e_req, e_wen;
        logic [15:0] e_inst, e_pc;
        @(negedge clk);
        reset     = rst;
        br_taken  = br;
        br_target = tgt;
        ir_ready  = rdy;
        if (mem_q.size() > 0 && mem_q[0].due == cyc) begin
            mem_rvalid = 1'b1;
            mem_rdata  = mem_q[0].data;
            void'(mem_q.pop_front());
        end else begin
            mem_rvalid = 1'b0;
            mem_rdata  = 16'($urandom);
        end
        #1;
        if (rst) begin
            e_req = 0; e_wen = 0; e_inst = NOP_INST; e_pc = RESET_PC;
        end else begin
            e_req  = !m_out && !br && m_buf.size() < 2;
            e_wen  = m_buf.size() > 0 && rdy && !br;
            e_inst = (m_buf.size() > 0) ? m_buf[0].inst : NOP_INST;
            e_pc   = (m_buf.size() > 0) ? m_buf[0].pc   : m_pc;
        end
        check("mem_req",  {15'd0, mem_req}, {15'd0, e_req});
        if (e_req) check("mem_addr", mem_addr, m_pc);
        check("ir_wen",   {15'd0, ir_wen},  {15'd0, e_wen});
        check("inst_out", inst_out, e_inst);
        check("pc_out",   pc_out,   e_pc);

        if (mem_req) begin
            int d = cyc + lat;
            if (d <= last_due) d = last_due + 1;
            last_due = d;
            mem_q.push_back('{d, mem_word(mem_addr)});
        end

        if (rst) begin
            m_buf.delete(); m_pc = RESET_PC; m_out = 0; m_drop = 0;
        end else if (br) begin
            m_buf.delete();
            m_pc = tgt;
            if (m_out && mem_rvalid) begin m_out = 0; m_drop = 0; end
            else if (m_out) m_drop = 1;
        end else begin
            if (e_wen) void'(m_buf.pop_front());
            if (m_out && mem_rvalid) begin
                if (!m_drop) m_buf.push_back('{m_req_pc, mem_rdata});
                m_out = 0; m_drop = 0;
            end else if (e_req) begin
                m_req_pc = m_pc;
                m_pc     = m_pc + 16'd1;
                m_out    = 1;
            end
        end
        cyc++;
    endtask

    function automatic logic [15:0] pick_tgt();
        case ($urandom_range(3))
            0:       return 16'h0040;
            1:       return 16'hFFFE;
            2:       return 16'hFFFF;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic run(input int n, input int lat_lo, input int lat_hi,
                       input int rdy_pct, input int br_pct, input int rst_pct);
        for (int i = 0; i < n; i++)
            step($urandom_range(99) < rst_pct, $urandom_range(99) < br_pct, pick_tgt(),
                 $urandom_range(99) < rdy_pct, $urandom_range(lat_hi, lat_lo));
    endtask

    initial begin
        reset = 1'b1; br_taken = 1'b0; br_target = 16'h0; ir_ready = 1'b0;
        mem_rvalid = 1'b0; mem_rdata = 16'h0;
        for (int i = 0; i < 3; i++) step(1, 0, 16'h0, 1, 1);
        // Latency 1, always ready: back-to-back fetch from RESET_PC.
        run(20, 1, 1, 100, 0, 0);
        // Stall with ready low until the buffer fills, then drain.
        for (int i = 0; i < 3; i++) step(1, 0, 16'h0, 0, 1);
        for (int i = 0; i < 10; i++) step(0, 0, 16'h0, 0, 1);
        run(10, 1, 1, 100, 0, 0);
        // Redirect while a latency-4 read is in flight.
        step(1, 0, 16'h0, 1, 4);
        step(0, 0, 16'h0, 1, 4);
        step(0, 0, 16'h0, 1, 4);
        step(0, 1, 16'h0040, 1, 4);
        run(12, 4, 4, 100, 0, 0);
        // Wrap across 16'hFFFF.
        step(0, 1, 16'hFFFE, 1, 1);
        run(10, 1, 1, 100, 0, 0);
        // Reset during a read whose response lands after release.
        step(1, 0, 16'h0, 1, 3);
        step(0, 0, 16'h0, 1, 3);
        step(1, 0, 16'h0, 1, 3);
        step(1, 0, 16'h0, 1, 3);
        run(12, 1, 2, 100, 0, 0);
        // Broad random mix of latency, backpressure, redirects and resets.
        run(4000, 1, 4, 70, 10, 2);
        run(2000, 1, 2, 40, 25, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter RESET_PC, default 16'h0000: fetch address loaded on reset.
REQ-002 Parameter NOP_INST, default 16'h4300: value driven on inst_out when no instruction is available.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 mem_req  output  1  one-cycle read request to instruction memory.
REQ-006 mem_addr  output  16  word address of the request; valid when mem_req=1.
REQ-007 mem_rvalid  input  1  read data valid; exactly one pulse per accepted request, any latency >=1 cycle.
REQ-008 mem_rdata  input  16  instruction word; valid when mem_rvalid=1.
REQ-009 ir_ready  input  1  instruction register can load this cycle.
REQ-010 ir_wen  output  1  write enable to instruction register.
REQ-011 inst_out  output  16  instruction presented to instruction register.
REQ-012 pc_out  output  16  address of the instruction on inst_out.
REQ-013 br_taken  input  1  redirect request; single-cycle pulse.
REQ-014 br_target  input  16  redirect address; valid when br_taken=1.

Function
REQ-015 Internal state: fetch_pc (16b), 2-entry FIFO of {pc, inst}, FSM states IDLE / WAIT / FLUSH.
REQ-016 Issue: in IDLE with br_taken=0 and (FIFO count)<2, mem_req=1 and mem_addr=fetch_pc; next cycle fetch_pc=fetch_pc+1 (16'hFFFF wraps to 16'h0000), req_pc captured, FSM->WAIT.
REQ-017 At most one request outstanding; mem_req=0 in WAIT and FLUSH.
REQ-018 WAIT with mem_rvalid=1 and br_taken=0: push {req_pc, mem_rdata} into FIFO; FSM->IDLE; new issue is allowed no earlier than the following cycle.
REQ-019 Delivery: ir_wen = (FIFO not empty) & ir_ready & ~br_taken; inst_out/pc_out = FIFO head; head popped on the same edge that ir_wen=1.
REQ-020 FIFO empty: inst_out=NOP_INST, pc_out=fetch_pc, ir_wen=0.
REQ-021 Minimum latency: mem_rvalid in cycle N -> ir_wen=1 with that word in cycle N+1 if ir_ready=1.
REQ-022 Simultaneous push and pop: both performed; count unchanged; order preserved (FIFO, no reordering).
REQ-023 Issue gating guarantees no push into a full FIFO; count is always in 0..2.
REQ-024 Redirect (br_taken=1), any state: FIFO cleared, fetch_pc<=br_target, no issue and no pop that cycle.
REQ-025 Redirect in WAIT with mem_rvalid=0 -> FLUSH; in WAIT with mem_rvalid=1 -> IDLE, data discarded.
REQ-026 FLUSH: next mem_rvalid is discarded, FSM->IDLE; a further redirect in FLUSH only updates fetch_pc (FSM stays FLUSH unless mem_rvalid=1 that cycle).
REQ-027 mem_rvalid in IDLE is ignored.
REQ-028 ir_ready=0 holds FIFO head and outputs stable; fetching continues until FIFO full.

Reset
REQ-029 reset=1 on a rising edge: fetch_pc=RESET_PC, FIFO empty, FSM=IDLE; takes priority over all other inputs.
REQ-030 Outputs during and after reset: mem_req=0, ir_wen=0, inst_out=NOP_INST, pc_out=RESET_PC (mem_req may rise in the first cycle after reset is released).
REQ-031 Reset mid-request: outstanding response is dropped (arrives in IDLE, per REQ-027).

Verification
REQ-032 Release reset, memory latency 1, ir_ready=1, words 16'h1111,16'h2222 at 0,1 -> mem_addr 0,1; ir_wen with inst_out 16'h1111/pc_out 0, then 16'h2222/pc_out 1; NOP_INST between.
REQ-033 ir_ready=0, latency 1 -> exactly two requests (addr 0,1), then mem_req stays 0; raising ir_ready delivers addr 0 then 1, then fetching resumes at addr 2.
REQ-034 Latency 4, br_taken with br_target=16'h0040 two cycles after issue at addr 0 -> late response discarded, ir_wen not asserted for it; next mem_addr=16'h0040.
REQ-035 fetch_pc=16'hFFFF -> request addr 16'hFFFF then 16'h0000; pc_out matches each.
REQ-036 reset asserted while in WAIT, response arrives after release -> ignored; first delivered instruction has pc_out=RESET_PC.
REQ-037 br_taken coincident with mem_rvalid in WAIT and FIFO holding one entry -> FIFO empty, ir_wen=0 that cycle, next mem_addr=br_target.
